// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO family.
package fifo_pkg;

  // Defaults shared with the original 16-bit x 64 FIFO top.
  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 64;

  // Read-mode selector values for the FWFT parameter.
  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  // Pointer width for a power-of-two depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Fill-level width: one extra bit so the value DEPTH itself is representable.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side signal bundle of sync_fifo_param.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
);
  localparam int unsigned CW = count_width(DEPTH);

  logic             clr;
  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  // User side: drives requests, observes data and status.
  modport master (
    output clr, w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  clr, w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_1clk.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem_1clk
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard/FWFT read modes, fill level,
// almost-full/empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned FWFT     = MODE_STD,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_acc, wr_acc;
  logic             mem_we;
  logic [WIDTH-1:0] rd_data;

  // Acceptance rules and next-state pointers, count and flags.
  always_comb begin
    rd_acc   = bus.r_en & ~empty_q;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    wr_acc   = bus.w_en & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    ovf_d   = ovf_q | (bus.w_en & ~wr_acc);
    udf_d   = udf_q | (bus.r_en & ~rd_acc);
  end

  // Control state; reset and flush return to empty, flush has priority over access.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Writes landing on a reset or flush edge are dropped.
  assign mem_we = wr_acc & rst_n & ~bus.clr;

  fifo_mem_1clk #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head of queue is always presented; meaningless while empty.
    assign bus.data_out = rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] data_out_q;

    // Registered read data: loads on an accepted read, holds across flush.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_out_q <= '0;
      end else if (!bus.clr && rd_acc) begin
        data_out_q <= rd_data;
      end
    end

    assign bus.data_out = data_out_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode and an FWFT instance share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned AF = 4;
  localparam int unsigned AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) sif ();
  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) fif ();

  sync_fifo_param #(
    .WIDTH (W), .DEPTH (D), .FWFT (0), .AF_LEVEL (AF), .AE_LEVEL (AE)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  sync_fifo_param #(
    .WIDTH (W), .DEPTH (D), .FWFT (1), .AF_LEVEL (AF), .AE_LEVEL (AE)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue contents, sticky flags, standard-mode output register.
  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic [W-1:0] m_dout = '0;

  function automatic logic [3:0] m_cnt();
    return 4'(q.size());
  endfunction

  // Apply one cycle of stimulus to both instances and advance the model.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                      input logic c, input logic rn);
    logic rd_ok, wr_ok;
    sif.w_en = w; sif.data_in = d; sif.r_en = r; sif.clr = c;
    fif.w_en = w; fif.data_in = d; fif.r_en = r; fif.clr = c;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    end else if (c) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rd_ok = r && (q.size() != 0);
      wr_ok = w && ((q.size() != D) || rd_ok);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_udf = 1'b1;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    n_checks++; if (sif.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sif.count); end
    n_checks++; if (sif.empty !== 1'b1 || sif.full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full: got %b%b want 10", sif.empty, sif.full); end
    n_checks++; if (sif.almost_empty !== 1'b1 || sif.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost: got ae=%b af=%b want ae=1 af=0", sif.almost_empty, sif.almost_full); end
    n_checks++; if (sif.overflow !== 1'b0 || sif.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b udf=%b want 0 0", sif.overflow, sif.underflow); end
    n_checks++; if (sif.data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", sif.data_out); end
    step(0, '0, 0, 0, 1);
    n_checks++; if (sif.empty !== 1'b1 || sif.count !== 4'd0) begin n_fail++; $display("FAIL post_reset_idle: got empty=%b count=%0d want 1 0", sif.empty, sif.count); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1, W'(i), 0, 0, 1);
      n_checks++; if (sif.count !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, sif.count, i); end
      n_checks++; if (sif.almost_full !== (i >= 4)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, sif.almost_full, (i >= 4)); end
      n_checks++; if (sif.full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, sif.full, (i == 8)); end
      n_checks++; if (sif.almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b want %b", i, sif.almost_empty, (i <= 2)); end
    end
    step(1, 16'h0009, 0, 0, 1);
    n_checks++; if (sif.count !== 4'd8 || sif.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got count=%0d ovf=%b want 8 1", sif.count, sif.overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      step(0, '0, 1, 0, 1);
      n_checks++; if (sif.data_out !== W'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, sif.data_out, W'(i)); end
    end
    n_checks++; if (sif.empty !== 1'b1 || sif.underflow !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got empty=%b udf=%b want 1 0", sif.empty, sif.underflow); end
    step(0, '0, 1, 0, 1);
    n_checks++; if (sif.underflow !== 1'b1 || sif.data_out !== 16'h0008) begin n_fail++; $display("FAIL drain_underflow: got udf=%b dout=%h want 1 0008", sif.underflow, sif.data_out); end
  endtask

  task automatic test_boundary();
    step(0, '0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 0, 1);
    step(1, 16'h00AA, 1, 0, 1);
    n_checks++; if (sif.count !== 4'd8 || sif.full !== 1'b1 || sif.overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw: got count=%0d full=%b ovf=%b want 8 1 0", sif.count, sif.full, sif.overflow); end
    n_checks++; if (sif.data_out !== m_dout) begin n_fail++; $display("FAIL full_rw_data: got %h want %h", sif.data_out, m_dout); end
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 0, 1);
      n_checks++; if (sif.data_out !== m_dout) begin n_fail++; $display("FAIL full_rw_drain[%0d]: got %h want %h", i, sif.data_out, m_dout); end
    end
    n_checks++; if (sif.data_out !== 16'h00AA) begin n_fail++; $display("FAIL full_rw_last: got %h want 00aa", sif.data_out); end
    step(1, 16'h0055, 1, 0, 1);
    n_checks++; if (sif.count !== 4'd1 || sif.underflow !== 1'b1) begin n_fail++; $display("FAIL empty_rw: got count=%0d udf=%b want 1 1", sif.count, sif.underflow); end
  endtask

  task automatic test_wrap();
    int nw = 0;
    int nr = 0;
    logic w, r;
    step(0, '0, 0, 1, 1);
    for (int cyc = 0; cyc < 300 && nr < 20; cyc++) begin
      if (nw < 2) begin
        w = 1'b1; r = 1'b0;
      end else begin
        w = (nw < 20) && (q.size() < 6) && ($urandom_range(0, 1) == 1);
        r = ((q.size() > 2) || (nw == 20 && q.size() > 0)) && ($urandom_range(0, 1) == 1);
      end
      if (r) begin
        n_checks++; if (fif.data_out !== W'(16'h0100 + nr)) begin n_fail++; $display("FAIL wrap_fwft[%0d]: got %h want %h", nr, fif.data_out, W'(16'h0100 + nr)); end
      end
      step(w, W'(16'h0100 + nw), r, 0, 1);
      if (w) nw++;
      if (r) begin
        n_checks++; if (sif.data_out !== W'(16'h0100 + nr)) begin n_fail++; $display("FAIL wrap_std[%0d]: got %h want %h", nr, sif.data_out, W'(16'h0100 + nr)); end
        nr++;
      end
      n_checks++; if (sif.count !== m_cnt()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", sif.count, m_cnt()); end
    end
    n_checks++; if (nr != 20) begin n_fail++; $display("FAIL wrap_budget: got %0d reads want 20", nr); end
  endtask

  task automatic test_fwft();
    step(0, '0, 0, 1, 1);
    step(1, 16'h1234, 0, 0, 1);
    n_checks++; if (fif.data_out !== 16'h1234 || fif.empty !== 1'b0) begin n_fail++; $display("FAIL fwft_first: got dout=%h empty=%b want 1234 0", fif.data_out, fif.empty); end
    step(0, '0, 1, 0, 1);
    n_checks++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b want 1", fif.empty); end
    step(1, 16'hBEEF, 0, 0, 1);
    step(1, 16'hCAFE, 0, 0, 1);
    n_checks++; if (fif.data_out !== 16'hBEEF) begin n_fail++; $display("FAIL fwft_head1: got %h want beef", fif.data_out); end
    step(0, '0, 1, 0, 1);
    n_checks++; if (fif.data_out !== 16'hCAFE || fif.empty !== 1'b0) begin n_fail++; $display("FAIL fwft_head2: got dout=%h empty=%b want cafe 0", fif.data_out, fif.empty); end
    step(0, '0, 1, 0, 1);
    n_checks++; if (fif.empty !== 1'b1 || fif.underflow !== 1'b0) begin n_fail++; $display("FAIL fwft_drained: got empty=%b udf=%b want 1 0", fif.empty, fif.underflow); end
  endtask

  // Bring the FIFO to count 5 with overflow set.
  task automatic prep_five_ovf();
    step(0, '0, 0, 1, 1);
    for (int i = 0; i < 9; i++) step(1, W'(16'h0200 + i), 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 1);
  endtask

  task automatic test_clear();
    prep_five_ovf();
    n_checks++; if (sif.count !== 4'd5 || sif.overflow !== 1'b1) begin n_fail++; $display("FAIL clr_setup: got count=%0d ovf=%b want 5 1", sif.count, sif.overflow); end
    step(1, 16'hDEAD, 0, 1, 1);
    n_checks++; if (sif.count !== 4'd0 || sif.empty !== 1'b1 || sif.overflow !== 1'b0) begin n_fail++; $display("FAIL clr_state: got count=%0d empty=%b ovf=%b want 0 1 0", sif.count, sif.empty, sif.overflow); end
    n_checks++; if (sif.data_out !== 16'h0202) begin n_fail++; $display("FAIL clr_dout_hold: got %h want 0202", sif.data_out); end
    step(0, '0, 0, 0, 1);
    n_checks++; if (sif.count !== 4'd0) begin n_fail++; $display("FAIL clr_write_dropped: got %0d want 0", sif.count); end
    prep_five_ovf();
    step(1, 16'hDEAD, 0, 0, 0);
    n_checks++; if (sif.count !== 4'd0 || sif.empty !== 1'b1 || sif.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_state: got count=%0d empty=%b ovf=%b want 0 1 0", sif.count, sif.empty, sif.overflow); end
    n_checks++; if (sif.data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_dout: got %h want 0000", sif.data_out); end
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic w, r, c, rn;
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 99) < 3);
      rn = ($urandom_range(0, 99) >= 1);
      step(w, W'($urandom), r, c, rn);
      n_checks++; if (sif.count !== m_cnt() || fif.count !== m_cnt()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d", i, sif.count, fif.count, m_cnt()); end
      n_checks++; if ({sif.full, sif.empty, sif.almost_full, sif.almost_empty} !== {q.size() == D, q.size() == 0, q.size() >= AF, q.size() <= AE}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b%b%b%b size %0d", i, sif.full, sif.empty, sif.almost_full, sif.almost_empty, q.size()); end
      n_checks++; if (sif.overflow !== m_ovf || sif.underflow !== m_udf) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b%b want %b%b", i, sif.overflow, sif.underflow, m_ovf, m_udf); end
      n_checks++; if (sif.data_out !== m_dout) begin n_fail++; $display("FAIL rnd_std_dout[%0d]: got %h want %h", i, sif.data_out, m_dout); end
      if (q.size() != 0) begin
        n_checks++; if (fif.data_out !== q[0]) begin n_fail++; $display("FAIL rnd_fwft_dout[%0d]: got %h want %h", i, fif.data_out, q[0]); end
      end
    end
  endtask

  initial begin
    sif.w_en = 1'b0; sif.r_en = 1'b0; sif.clr = 1'b0; sif.data_in = '0;
    fif.w_en = 1'b0; fif.r_en = 1'b0; fif.clr = 1'b0; fif.data_in = '0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_boundary();
    test_wrap();
    test_fwft();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
